// File: rtl/seg_display_scanner.sv
// seg_display_scanner: time-multiplexed scanner for a 4-digit seven-segment display.
// Latency: outputs are decoded from registers; they change in the cycle after a divider tick.
// Backpressure: none; LOAD is always accepted and the last LOAD before a frame boundary wins.
// Ports: clk_i, rst_i (async, active-high), enable_i, load_i, value_i[15:0], dots_i[3:0] in;
//        seg_select_o[1:0], bin_o[3:0], dot_o, blank_o, pending_o, frame_done_o out.
module seg_display_scanner #(
    parameter int unsigned CLK_DIV       = 100000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        load_i,
    input  logic [15:0] value_i,
    input  logic [3:0]  dots_i,
    output logic [1:0]  seg_select_o,
    output logic [3:0]  bin_o,
    output logic        dot_o,
    output logic        blank_o,
    output logic        pending_o,
    output logic        frame_done_o
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   disp_val_q, disp_val_d;
    logic [3:0]    disp_dots_q, disp_dots_d;
    logic [15:0]   pend_val_q, pend_val_d;
    logic [3:0]    pend_dots_q, pend_dots_d;
    logic          pend_flag_q, pend_flag_d;
    logic          frame_done_q, frame_done_d;

    logic tick;
    logic boundary;

    always_comb begin
        tick     = enable_i && (cnt_q == CNT_MAX);
        boundary = tick && (idx_q == 2'd3);

        cnt_d        = cnt_q;
        idx_d        = idx_q;
        disp_val_d   = disp_val_q;
        disp_dots_d  = disp_dots_q;
        pend_val_d   = pend_val_q;
        pend_dots_d  = pend_dots_q;
        pend_flag_d  = pend_flag_q;
        frame_done_d = boundary;

        if (enable_i) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
        if (tick) begin
            idx_d = idx_q + 2'd1;
        end

        // Transfer reads the pending registers as they were before this edge,
        // so a LOAD in the same cycle is captured for the following frame.
        if (boundary && pend_flag_q) begin
            disp_val_d  = pend_val_q;
            disp_dots_d = pend_dots_q;
            pend_flag_d = 1'b0;
        end
        if (load_i) begin
            pend_val_d  = value_i;
            pend_dots_d = dots_i;
            pend_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            disp_val_q   <= 16'h0000;
            disp_dots_q  <= 4'h0;
            pend_val_q   <= 16'h0000;
            pend_dots_q  <= 4'h0;
            pend_flag_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_val_q   <= disp_val_d;
            disp_dots_q  <= disp_dots_d;
            pend_val_q   <= pend_val_d;
            pend_dots_q  <= pend_dots_d;
            pend_flag_q  <= pend_flag_d;
            frame_done_q <= frame_done_d;
        end
    end

    // A digit is a leading zero when it and every more-significant nibble are zero.
    logic upper_zero;

    always_comb begin
        upper_zero = 1'b0;
        case (idx_q)
            2'd1:    upper_zero = (disp_val_q[15:4]  == 12'h000);
            2'd2:    upper_zero = (disp_val_q[15:8]  == 8'h00);
            2'd3:    upper_zero = (disp_val_q[15:12] == 4'h0);
            default: upper_zero = 1'b0;
        endcase
    end

    always_comb begin
        seg_select_o = idx_q;
        bin_o        = disp_val_q[{idx_q, 2'b00} +: 4];
        dot_o        = disp_dots_q[idx_q];
        blank_o      = BLANK_LEADING && (idx_q != 2'd0) && upper_zero && !disp_dots_q[idx_q];
        pending_o    = pend_flag_q;
        frame_done_o = frame_done_q;
    end

endmodule
